// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared encodings for the memory stage
//
// Purpose: result-select encodings, funct3 access-size encodings, the
// decoded access size, the memory-stage FSM state type, and a helper that
// turns funct3 into an access size.
// Ports: none (package).
package memory_stage_pkg;

    // ResultSrc encodings (what writeback selects)
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // funct3 load/store size encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } accSize_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } memState_t;

    // Reserved funct3 codes fall through to a word access.
    function automatic accSize_t decodeSize(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: decodeSize = SZ_B;
            F3_H, F3_HU: decodeSize = SZ_H;
            default:     decodeSize = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// rtl/memory_stage_load_align.sv - load byte/half select and extension
//
// Purpose: picks the byte or halfword addressed by byteOff out of the read
// word and sign- or zero-extends it according to funct3; word loads and
// reserved codes pass the word through.
// Ports:
//   funct3   in  3   access size/sign
//   byteOff  in  2   address bits [1:0]
//   rdata    in  32  word returned by data memory
//   loadData out 32  aligned, extended load value
import memory_stage_pkg::*;

module memory_stage_load_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  byteOff,
    input  logic [31:0] rdata,
    output logic [31:0] loadData
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    always_comb begin
        selByte = 8'h00;
        case (byteOff)
            2'd0: selByte = rdata[7:0];
            2'd1: selByte = rdata[15:8];
            2'd2: selByte = rdata[23:16];
            2'd3: selByte = rdata[31:24];
            default: selByte = 8'h00;
        endcase
        // Halfword accesses are only issued on even addresses, so bit 1 alone picks the half.
        selHalf = byteOff[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    loadData = {{24{selByte[7]}}, selByte};
            F3_H:    loadData = {{16{selHalf[15]}}, selHalf};
            F3_BU:   loadData = {24'h000000, selByte};
            F3_HU:   loadData = {16'h0000, selHalf};
            default: loadData = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RISC-V memory stage with ready-handshaked data port
//
// Purpose: issues loads/stores to data memory, stalls upstream while the
// memory has not answered, drops misaligned accesses, and registers the
// MEM/WB pipeline outputs.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   RegWriteM..PCPlus4M           EX/MEM register outputs
//   StallM, MisalignM             hold upstream / misaligned-access pulse
//   dmem_req/we/addr/wdata/be     data-memory request
//   dmem_ready, dmem_rdata        data-memory response
//   RegWriteW..PCPlus4W           MEM/WB register outputs
import memory_stage_pkg::*;

module memory_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic              MemWriteM,
    input  logic [2:0]        funct3M,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [4:0]        RdM,
    input  logic [31:0]       PCPlus4M,
    output logic              StallM,
    output logic              MisalignM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [31:0]       ReadDataW,
    output logic [31:0]       ALUResultW,
    output logic [4:0]        RdW,
    output logic [31:0]       PCPlus4W
);

    memState_t   state;
    accSize_t    accSize;
    logic        access;
    logic        aligned;
    logic [1:0]  lane;
    logic [31:0] loadData;

    assign accSize = decodeSize(funct3M);
    assign access  = MemWriteM | (ResultSrcM == RES_MEM);
    assign lane    = ALUResultM[1:0];

    always_comb begin
        case (accSize)
            SZ_H:    aligned = ~ALUResultM[0];
            SZ_W:    aligned = (ALUResultM[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    // Gating with rst makes the request drop the instant reset asserts,
    // including mid-WAIT. In WAIT the inputs are frozen by the stall, so the
    // request terms stay identical until ready.
    assign dmem_req  = rst & ((state == S_WAIT) | (access & aligned));
    assign MisalignM = rst & (state == S_IDLE) & access & ~aligned;
    assign StallM    = dmem_req & ~dmem_ready;
    assign dmem_we   = dmem_req & MemWriteM;
    assign dmem_addr = {ALUResultM[ADDR_W-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = WriteDataM;
        if (MemWriteM) begin
            case (accSize)
                SZ_B: begin
                    dmem_be    = 4'b0001 << lane;
                    dmem_wdata = {4{WriteDataM[7:0]}};
                end
                SZ_H: begin
                    dmem_be    = 4'b0011 << lane;
                    dmem_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = WriteDataM;
                end
            endcase
        end
    end

    memory_stage_load_align uLoadAlign (
        .funct3   (funct3M),
        .byteOff  (lane),
        .rdata    (dmem_rdata),
        .loadData (loadData)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ReadDataW  <= 32'h0;
            ALUResultW <= 32'h0;
            RdW        <= 5'd0;
            PCPlus4W   <= 32'h0;
        end else begin
            state <= StallM ? S_WAIT : S_IDLE;
            if (StallM) begin
                // Bubble while waiting; other fields hold.
                RegWriteW <= 1'b0;
            end else begin
                RegWriteW  <= RegWriteM & ~MisalignM;
                ResultSrcW <= ResultSrcM;
                ALUResultW <= ALUResultM;
                RdW        <= RdM;
                PCPlus4W   <= PCPlus4M;
                if (dmem_req & ~MemWriteM)
                    ReadDataW <= loadData;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        StallM, MisalignM;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
    logic [4:0]  RdW;

    int total = 0;
    int bad   = 0;
    logic [31:0] lastLoad = 32'h0;

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M),
        .StallM(StallM), .MisalignM(MisalignM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
        .ALUResultW(ALUResultW), .RdW(RdW), .PCPlus4W(PCPlus4W)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: access size in bytes (1, 2, 4) straight from the funct3 table.
    function automatic int sizeOf(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
        int sz = sizeOf(f3);
        longint unsigned raw;
        longint signed   sv;
        raw = (longint'(word) >> (8 * (addr % 4))) & ((64'd1 << (8 * sz)) - 1);
        if (sz == 4) return word;
        if (f3 == 3'b100 || f3 == 3'b101) return raw[31:0];
        sv = (raw >= (64'd1 << (8 * sz - 1))) ? longint'(raw) - longint'(64'd1 << (8 * sz)) : longint'(raw);
        return sv[31:0];
    endfunction

    // One instruction through the stage; nWait = cycles dmem_ready stays low.
    task automatic runTxn(input logic rw, input logic [1:0] res, input logic mw,
                          input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] pc4, input int nWait,
                          input logic [31:0] rdata);
        logic isAcc, isAl, expReq;
        int   sz;
        logic [31:0] expBe, expWd;
        isAcc  = mw || (res == 2'b01);
        sz     = sizeOf(f3);
        isAl   = (alu % sz) == 0;
        expReq = isAcc && isAl;
        if (mw && sz == 1)      begin expBe = 32'(1 << (alu % 4)); expWd = wd[7:0]  * 32'h01010101; end
        else if (mw && sz == 2) begin expBe = 32'(3 << (alu % 4)); expWd = wd[15:0] * 32'h00010001; end
        else                    begin expBe = 32'hF;               expWd = wd;                      end

        RegWriteM = rw; ResultSrcM = res; MemWriteM = mw; funct3M = f3;
        ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
        dmem_rdata = rdata;
        dmem_ready = expReq ? (nWait == 0) : 1'($urandom_range(0, 1));

        @(negedge clk);
        chk("req", 32'(dmem_req), 32'(expReq));
        chk("misalign", 32'(MisalignM), 32'(isAcc && !isAl));
        chk("stall", 32'(StallM), 32'(expReq && nWait > 0));
        if (expReq) begin
            chk("addr", dmem_addr, alu & 32'hFFFF_FFFC);
            chk("we", 32'(dmem_we), 32'(mw));
            chk("be", 32'(dmem_be), expBe);
            if (mw) chk("wdata", dmem_wdata, expWd);
            for (int k = 0; k < nWait; k++) begin
                @(posedge clk); #1;
                chk("bubble", 32'(RegWriteW), 32'h0);
                dmem_ready = (k == nWait - 1);
                @(negedge clk);
                chk("waitReq", 32'(dmem_req), 32'h1);
                chk("waitAddr", dmem_addr, alu & 32'hFFFF_FFFC);
                chk("waitBe", 32'(dmem_be), expBe);
                chk("waitStall", 32'(StallM), 32'(k < nWait - 1));
            end
        end
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        chk("RegWriteW", 32'(RegWriteW), 32'(rw && !(isAcc && !isAl)));
        chk("RdW", 32'(RdW), 32'(rd));
        chk("ALUResultW", ALUResultW, alu);
        chk("PCPlus4W", PCPlus4W, pc4);
        chk("ResultSrcW", 32'(ResultSrcW), 32'(res));
        if (expReq && !mw) lastLoad = refLoad(f3, alu, rdata);
        chk("ReadDataW", ReadDataW, lastLoad);
    endtask

    initial begin
        rst = 1'b0;
        RegWriteM = 0; ResultSrcM = 2'b01; MemWriteM = 0; funct3M = 3'b010;
        ALUResultM = 32'h100; WriteDataM = 0; RdM = 0; PCPlus4M = 0;
        dmem_ready = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(StallM), 32'h0);
        chk("rst_misalign", 32'(MisalignM), 32'h0);
        chk("rst_RegWriteW", 32'(RegWriteW), 32'h0);
        chk("rst_ALUResultW", ALUResultW, 32'h0);
        chk("rst_ReadDataW", ReadDataW, 32'h0);
        ResultSrcM = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the stage's intended behaviour
        runTxn(1, 2'b00, 0, 3'b000, 32'h1234, 0, 5'd5, 32'h40, 0, 0);
        runTxn(1, 2'b01, 0, 3'b010, 32'h100, 0, 5'd6, 32'h44, 0, 32'hDEADBEEF);
        chk("lw_data", ReadDataW, 32'hDEADBEEF);
        runTxn(1, 2'b01, 0, 3'b000, 32'h103, 0, 5'd7, 32'h48, 2, 32'h80FFFFFF);
        chk("lb_data", ReadDataW, 32'hFFFFFF80);
        runTxn(1, 2'b01, 0, 3'b100, 32'h103, 0, 5'd7, 32'h4C, 1, 32'h80FFFFFF);
        chk("lbu_data", ReadDataW, 32'h00000080);
        runTxn(0, 2'b00, 1, 3'b001, 32'h202, 32'h0000ABCD, 5'd0, 32'h50, 0, 0);
        runTxn(1, 2'b01, 0, 3'b010, 32'h101, 0, 5'd8, 32'h54, 0, 0);
        runTxn(1, 2'b01, 0, 3'b101, 32'h102, 0, 5'd9, 32'h58, 0, 32'h8765_4321);
        chk("lhu_data", ReadDataW, 32'h0000_8765);

        // Reset during WAIT
        RegWriteM = 1; ResultSrcM = 2'b01; MemWriteM = 0; funct3M = 3'b010;
        ALUResultM = 32'h300; RdM = 5'd3; PCPlus4M = 32'h60; dmem_ready = 0;
        @(posedge clk); #1;
        chk("pre_rst_stall", 32'(StallM), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("wrst_req", 32'(dmem_req), 32'h0);
        chk("wrst_stall", 32'(StallM), 32'h0);
        chk("wrst_RdW", 32'(RdW), 32'h0);
        chk("wrst_ALUResultW", ALUResultW, 32'h0);
        chk("wrst_PCPlus4W", PCPlus4W, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        lastLoad = 32'h0;
        runTxn(1, 2'b01, 0, 3'b010, 32'h400, 0, 5'd10, 32'h64, 1, 32'h1357_9BDF);
        chk("post_rst_lw", ReadDataW, 32'h1357_9BDF);

        // Randomized mix
        for (int i = 0; i < 300; i++) begin
            int kind = $urandom_range(0, 3);
            logic [31:0] alu = $urandom;
            logic [2:0]  f3  = 3'($urandom_range(0, 7));
            int nw = $urandom_range(0, 3);
            case (kind)
                0: runTxn(1, 2'b00, 0, f3, alu, $urandom, 5'($urandom), $urandom, nw, $urandom);
                1: runTxn(1, 2'b10, 0, f3, alu, $urandom, 5'($urandom), $urandom, nw, $urandom);
                2: runTxn(1, 2'b01, 0, f3, alu, $urandom, 5'($urandom), $urandom, nw, $urandom);
                default: runTxn(0, 2'b00, 1, f3, alu, $urandom, 5'($urandom), $urandom, nw, $urandom);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the five-stage RISC-V pipeline. It sits between the execute stage's EX/MEM pipeline register outputs and the writeback stage. It performs loads and stores over a ready-handshaked data-memory port, sizes and extends load data, stalls the upstream pipeline while memory is busy, and registers the MEM/WB pipeline outputs.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-low reset
- RegWriteM  in  1  instruction writes rd
- ResultSrcM  in  2  result select: 00 ALU, 01 load data, 10 PC+4
- MemWriteM  in  1  store
- funct3M  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ALUResultM  in  32  effective address or ALU result
- WriteDataM  in  32  store data (rs2)
- RdM  in  5  destination register
- PCPlus4M  in  32  link value
- StallM  out  1  hold EX/MEM and all earlier stages
- MisalignM  out  1  one-cycle pulse: misaligned access dropped
- dmem_req  out  1  access request
- dmem_we  out  1  write enable
- dmem_addr  out  ADDR_W  word-aligned address (ALUResultM[ADDR_W-1:2], 2'b00)
- dmem_wdata  out  32  lane-shifted store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access complete (read data valid this cycle)
- dmem_rdata  in  32  read word
- RegWriteW, ResultSrcW[1:0], ReadDataW[31:0], ALUResultW[31:0], RdW[4:0], PCPlus4W[31:0]  out  MEM/WB register outputs

## Operation
- Access = MemWriteM | (ResultSrcM==01). Non-access instructions pass straight to MEM/WB in one cycle.
- FSM states: IDLE, WAIT.
  - IDLE with access, aligned: drive dmem_req=1 combinationally.
    - dmem_ready=1 the same cycle: complete; no stall.
    - Otherwise: StallM=1; go to WAIT.
  - WAIT: dmem_req=1 and StallM=1. Inputs are stable because upstream is stalled.
    - On dmem_ready: StallM=0; capture into MEM/WB; return to IDLE.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
  - Violation: no request; MisalignM=1 for that cycle; MEM/WB gets a bubble (RegWriteW=0).
- Stores: byte lane = addr[1:0].
  - sb: be=0001<<lane; wdata = byte replicated ×4.
  - sh: be=0011<<lane; wdata = halfword replicated ×2.
  - sw: be=1111.
  - Loads: be=1111, dmem_we=0.
- Loads: select the byte or halfword at addr[1:0], then sign-extend (b, h) or zero-extend (bu, hu). Word loads pass through. The result goes to ReadDataW.
- Reserved funct3 (011, 110, 111) on an access: treated as word.
- While StallM=1, MEM/WB loads a bubble each cycle: RegWriteW=0, other fields hold.

## Timing
- Reset (rst=0, asynchronous): state=IDLE.
  - All W outputs=0; dmem_req=0; StallM=0; MisalignM=0.
- Latency: one clock from M inputs to W outputs for non-access and zero-wait accesses. For N ready-wait cycles, latency is 1+N and StallM is high for N cycles.
- dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata stay stable from request until the cycle dmem_ready is seen. dmem_ready outside a request is ignored.
- Reset during WAIT: dmem_req drops immediately, and the pending access is abandoned.
- A store completes with RegWriteW as presented; the decoder guarantees RegWriteM=0 for stores.

## Structure
- Shared package: ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4), funct3 load/store size encodings, FSM state typedef.
- One natural sub-module: load_align (combinational byte/half select plus sign or zero extension from funct3 and addr[1:0]). Store lane shifting stays inline.

## Test plan
- Non-access: ALUResultM=0x1234, RegWriteM=1, RdM=5, ResultSrcM=00 -> next edge ALUResultW=0x1234, RdW=5, RegWriteW=1, StallM never high.
- Zero-wait lw: addr 0x100, dmem_ready=1 same cycle, rdata=0xDEADBEEF -> ReadDataW=0xDEADBEEF one cycle later, no stall.
- lb with sign extension, 2-cycle wait: addr 0x103, rdata=0x80FFFFFF, ready after 2 cycles -> StallM high 2 cycles, dmem_addr=0x100 stable, ReadDataW=0xFFFFFF80; lbu gives 0x00000080.
- sh to 0x202, WriteDataM=0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
- Misaligned lw at 0x101 -> no dmem_req, MisalignM pulse, RegWriteW=0.
- rst low during WAIT -> dmem_req, StallM and W outputs go to 0 immediately; after release, a new lw completes normally.
